// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store via IDLE/ISSUE/WAIT/RESP; request->valid >= 3 cycles.
// Requests hold until their valid; data wins unless fetch starved STARVE_LIMIT times; `ARB_TIMEOUT_EN adds WAIT timeout + err.
module mem_port_arbiter #(
    parameter int DataWidth    = 32,
    parameter int Address      = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_request,
    input  logic [Address-1:0]   i_address,
    output logic                 i_valid,
    output logic [DataWidth-1:0] i_data_out,
    input  logic                 d_request,
    input  logic                 d_we_re,
    input  logic [3:0]           d_mask,
    input  logic [Address-1:0]   d_address,
    input  logic [DataWidth-1:0] d_data_in,
    output logic                 d_valid,
    output logic [DataWidth-1:0] d_data_out,
    output logic                 err,
    output logic                 mem_request,
    output logic                 mem_we_re,
    output logic [3:0]           mem_mask,
    output logic [Address-1:0]   mem_address,
    output logic [DataWidth-1:0] mem_data_in,
    input  logic                 mem_valid,
    input  logic [DataWidth-1:0] mem_data_out
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    localparam int StreakW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    state_t                 state_q, state_d;
    owner_t                 owner_q, owner_d;
    logic [StreakW-1:0]     streak_q, streak_d;
    logic                   we_q, we_d;
    logic [3:0]             mask_q, mask_d;
    logic [Address-1:0]     addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   data_wins;

`ifdef ARB_TIMEOUT_EN
    localparam int ToW = $clog2(TIMEOUT_CYC);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC > 1);
`endif

    // Fetch only overtakes data once it has been passed over STARVE_LIMIT times in a row.
    assign data_wins = d_request && !(i_request && (streak_q == StreakMax));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        we_d     = we_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_request || d_request) begin
                    state_d = S_ISSUE;
                    err_d   = 1'b0;
                    if (data_wins) begin
                        owner_d = OWN_D;
                        we_d    = d_we_re;
                        mask_d  = d_mask;
                        addr_d  = d_address;
                        wdata_d = d_data_in;
                        if (i_request && (streak_q != StreakMax)) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        owner_d  = OWN_I;
                        we_d     = 1'b0;
                        mask_d   = 4'hF;
                        addr_d   = i_address;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_valid) begin
                    rdata_d = we_q ? '0 : mem_data_out;
                    state_d = S_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_q == ToLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (!i_request) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_NONE;
            streak_q <= '0;
            we_q     <= 1'b0;
            mask_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            we_q     <= we_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign mem_request = (state_q == S_ISSUE);
    assign mem_we_re   = we_q;
    assign mem_mask    = mask_q;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

    assign i_valid    = (state_q == S_RESP) && (owner_q == OWN_I);
    assign d_valid    = (state_q == S_RESP) && (owner_q == OWN_D);
    assign i_data_out = i_valid ? rdata_q : '0;
    assign d_data_out = d_valid ? rdata_q : '0;
`ifdef ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
